// File: rtl/combat_unit.sv
// One lane unit (enemy or player): deploys from a one-hot type select, walks
// on game ticks, strobes attacks on a cooldown while blocked, dies and respawns.
module combat_unit #(
  parameter int POS_W         = 9,
  parameter int HP_W          = 8,
  parameter int DMG_W         = 8,
  parameter int NUM_TYPES     = 4,
  parameter int HP_MAX        = 255,
  parameter int POWER_BASE    = 16,
  parameter int START_POS     = 0,
  parameter int END_POS       = 319,
  parameter int DIR           = 0,
  parameter int ATTACK_PERIOD = 4,
  parameter int DEAD_HOLD     = 10,
  localparam int TW           = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 game_tick_i,
  input  logic [NUM_TYPES-1:0] deploy_req_i,
  input  logic                 move_scen_i,
  input  logic                 damage_scen_i,
  input  logic [DMG_W-1:0]     damage_in_i,
  output logic [POS_W-1:0]     position_o,
  output logic [DMG_W-1:0]     damage_out_o,
  output logic [HP_W-1:0]      health_o,
  output logic [TW-1:0]        unit_type_o,
  output logic                 alive_o,
  output logic                 dead_o,
  output logic                 reached_end_o
);

  localparam int CDW = (ATTACK_PERIOD > 1) ? $clog2(ATTACK_PERIOD + 1) : 1;
  localparam int DCW = (DEAD_HOLD > 1) ? $clog2(DEAD_HOLD + 1) : 1;
  localparam int CW  = (HP_W > DMG_W) ? HP_W : DMG_W;
  localparam int WW  = DMG_W + NUM_TYPES;

  typedef enum logic [1:0] {S_IDLE, S_DEPLOY, S_ALIVE, S_DEAD} state_e;

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [DMG_W-1:0] dmg_q, dmg_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [TW-1:0]    type_q, type_d;
  logic [DMG_W-1:0] power_q, power_d;
  logic [CDW-1:0]   cd_q, cd_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;
  logic             alive_q, dead_q, reached_q;

  logic             dep_onehot;
  logic [TW-1:0]    dep_idx;
  logic [WW-1:0]    power_wide;
  logic [DMG_W-1:0] power_sel;
  logic             kill;

  always_comb begin
    dep_idx    = '0;
    dep_onehot = ($countones(deploy_req_i) == 1);
    for (int i = 0; i < NUM_TYPES; i++)
      if (deploy_req_i[i]) dep_idx = TW'(i);
  end

  // Power doubles per type index; anything that spills past DMG_W saturates.
  always_comb begin
    power_wide = WW'(POWER_BASE) << type_q;
    power_sel  = (|power_wide[WW-1:DMG_W]) ? '1 : power_wide[DMG_W-1:0];
  end

  assign kill = damage_scen_i && (CW'(damage_in_i) >= CW'(hp_q));

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dmg_d   = '0;
    hp_d    = hp_q;
    type_d  = type_q;
    power_d = power_q;
    cd_d    = cd_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE: begin
        pos_d  = POS_W'(START_POS);
        hp_d   = '0;
        cd_d   = '0;
        dcnt_d = '0;
        if (dep_onehot) begin
          type_d  = dep_idx;
          state_d = S_DEPLOY;
        end
      end
      S_DEPLOY: begin
        hp_d    = HP_W'(HP_MAX);
        power_d = power_sel;
        pos_d   = POS_W'(START_POS);
        cd_d    = '0;
        state_d = S_ALIVE;
      end
      S_ALIVE: begin
        if (kill) begin
          // A lethal hit pre-empts any move or attack on the same cycle.
          hp_d    = '0;
          dcnt_d  = '0;
          state_d = S_DEAD;
        end else begin
          if (damage_scen_i) hp_d = hp_q - HP_W'(damage_in_i);
          if (game_tick_i) begin
            if (move_scen_i) begin
              cd_d = '0;
              if (DIR == 0) begin
                if (pos_q < POS_W'(END_POS)) pos_d = pos_q + POS_W'(1);
              end else begin
                if (pos_q > POS_W'(END_POS)) pos_d = pos_q - POS_W'(1);
              end
            end else if (cd_q == '0) begin
              dmg_d = power_q;
              cd_d  = CDW'(ATTACK_PERIOD - 1);
            end else begin
              cd_d = cd_q - CDW'(1);
            end
          end
        end
      end
      S_DEAD: begin
        if (dcnt_q == DCW'(DEAD_HOLD - 1)) begin
          dcnt_d  = '0;
          pos_d   = POS_W'(START_POS);
          state_d = S_IDLE;
        end else begin
          dcnt_d = dcnt_q + DCW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      pos_q     <= POS_W'(START_POS);
      dmg_q     <= '0;
      hp_q      <= '0;
      type_q    <= '0;
      power_q   <= '0;
      cd_q      <= '0;
      dcnt_q    <= '0;
      alive_q   <= 1'b0;
      dead_q    <= 1'b0;
      reached_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      dmg_q     <= dmg_d;
      hp_q      <= hp_d;
      type_q    <= type_d;
      power_q   <= power_d;
      cd_q      <= cd_d;
      dcnt_q    <= dcnt_d;
      alive_q   <= (state_d == S_ALIVE);
      dead_q    <= (state_d == S_DEAD);
      reached_q <= (state_d == S_ALIVE) && (pos_d == POS_W'(END_POS));
    end
  end

  assign position_o    = pos_q;
  assign damage_out_o  = dmg_q;
  assign health_o      = hp_q;
  assign unit_type_o   = type_q;
  assign alive_o       = alive_q;
  assign dead_o        = dead_q;
  assign reached_end_o = reached_q;

endmodule

// File: tb/tb_combat_unit.sv
// Directed bench for combat_unit: a vector table for deploy/move/attack/damage
// plus hand sequences for dead hold, respawn, multi-bit deploy and reset.
module tb_combat_unit;

  logic       clk = 1'b0;
  logic       rst_n, tick, mv, ds;
  logic [3:0] dep;
  logic [7:0] din;

  logic [8:0] pos0, pos1, pos2;
  logic [7:0] dmg0, dmg1, dmg2, hp0, hp1, hp2;
  logic [1:0] typ0, typ1, typ2;
  logic       al0, al1, al2, de0, de1, de2, re0, re1, re2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  combat_unit u0 (
    .clk_i(clk), .reset_ni(rst_n), .game_tick_i(tick), .deploy_req_i(dep),
    .move_scen_i(mv), .damage_scen_i(ds), .damage_in_i(din),
    .position_o(pos0), .damage_out_o(dmg0), .health_o(hp0), .unit_type_o(typ0),
    .alive_o(al0), .dead_o(de0), .reached_end_o(re0));

  combat_unit #(.START_POS(319), .END_POS(0), .DIR(1)) u1 (
    .clk_i(clk), .reset_ni(rst_n), .game_tick_i(tick), .deploy_req_i(dep),
    .move_scen_i(mv), .damage_scen_i(ds), .damage_in_i(din),
    .position_o(pos1), .damage_out_o(dmg1), .health_o(hp1), .unit_type_o(typ1),
    .alive_o(al1), .dead_o(de1), .reached_end_o(re1));

  combat_unit #(.START_POS(317), .END_POS(319)) u2 (
    .clk_i(clk), .reset_ni(rst_n), .game_tick_i(tick), .deploy_req_i(dep),
    .move_scen_i(mv), .damage_scen_i(ds), .damage_in_i(din),
    .position_o(pos2), .damage_out_o(dmg2), .health_o(hp2), .unit_type_o(typ2),
    .alive_o(al2), .dead_o(de2), .reached_end_o(re2));

  typedef struct {
    logic       rn, tk;
    logic [3:0] dp;
    logic       m, d;
    logic [7:0] dn;
    int pos, dmg, hp, typ, al, de, p1, p2, r2;
  } vec_t;

  function automatic vec_t mk(input logic rn, tk, input logic [3:0] dp,
                              input logic m, d, input logic [7:0] dn,
                              input int pos, dmg, hp, typ, al, de, p1, p2, r2);
    vec_t v;
    v.rn = rn; v.tk = tk; v.dp = dp; v.m = m; v.d = d; v.dn = dn;
    v.pos = pos; v.dmg = dmg; v.hp = hp; v.typ = typ; v.al = al; v.de = de;
    v.p1 = p1; v.p2 = p2; v.r2 = r2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rn, tk, input logic [3:0] dp,
                       input logic m, d, input logic [7:0] dn);
    rst_n = rn; tick = tk; dep = dp; mv = m; ds = d; din = dn;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_u0(input string tag, input int pos, dmg, hp, typ, al, de, re);
    chk({tag, ".pos"}, 32'(pos0), pos);
    chk({tag, ".dmg"}, 32'(dmg0), dmg);
    chk({tag, ".hp"},  32'(hp0), hp);
    chk({tag, ".typ"}, 32'(typ0), typ);
    chk({tag, ".alive"}, 32'(al0), al);
    chk({tag, ".dead"},  32'(de0), de);
    chk({tag, ".reach"}, 32'(re0), re);
  endtask

  vec_t tbl[16];

  initial begin
    rst_n = 1'b0; tick = 1'b0; dep = '0; mv = 1'b0; ds = 1'b0; din = '0;

    //            rn tk dep      m  d  din   pos dmg hp  typ al de  p1  p2  r2
    tbl[0]  = mk(0, 0, 4'b0100, 0, 0, 0,    0,  0,  0,  0,  0, 0, 319, 317, 0);
    tbl[1]  = mk(0, 0, 4'b0100, 0, 0, 0,    0,  0,  0,  0,  0, 0, 319, 317, 0);
    tbl[2]  = mk(1, 0, 4'b0100, 0, 0, 0,    0,  0,  0,  2,  0, 0, 319, 317, 0);
    tbl[3]  = mk(1, 0, 4'b0000, 0, 0, 0,    0,  0,  255, 2, 1, 0, 319, 317, 0);
    tbl[4]  = mk(1, 1, 4'b0000, 0, 0, 0,    0,  64, 255, 2, 1, 0, 319, 317, 0);
    tbl[5]  = mk(1, 0, 4'b0001, 0, 0, 0,    0,  0,  255, 2, 1, 0, 319, 317, 0);
    tbl[6]  = mk(1, 1, 4'b0000, 1, 0, 0,    1,  0,  255, 2, 1, 0, 318, 318, 0);
    tbl[7]  = mk(1, 1, 4'b0000, 1, 0, 0,    2,  0,  255, 2, 1, 0, 317, 319, 1);
    tbl[8]  = mk(1, 1, 4'b0000, 1, 0, 0,    3,  0,  255, 2, 1, 0, 316, 319, 1);
    tbl[9]  = mk(1, 1, 4'b0000, 0, 0, 0,    3,  64, 255, 2, 1, 0, 316, 319, 1);
    tbl[10] = mk(1, 1, 4'b0000, 0, 0, 0,    3,  0,  255, 2, 1, 0, 316, 319, 1);
    tbl[11] = mk(1, 1, 4'b0000, 0, 0, 0,    3,  0,  255, 2, 1, 0, 316, 319, 1);
    tbl[12] = mk(1, 1, 4'b0000, 0, 0, 0,    3,  0,  255, 2, 1, 0, 316, 319, 1);
    tbl[13] = mk(1, 1, 4'b0000, 0, 0, 0,    3,  64, 255, 2, 1, 0, 316, 319, 1);
    tbl[14] = mk(1, 0, 4'b0000, 0, 1, 200,  3,  0,  55,  2, 1, 0, 316, 319, 1);
    tbl[15] = mk(1, 1, 4'b0000, 1, 1, 55,   3,  0,  0,   2, 0, 1, 316, 319, 0);

    for (int i = 0; i < 16; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      drive(tbl[i].rn, tbl[i].tk, tbl[i].dp, tbl[i].m, tbl[i].d, tbl[i].dn);
      chk_u0(tag, tbl[i].pos, tbl[i].dmg, tbl[i].hp, tbl[i].typ, tbl[i].al, tbl[i].de, 0);
      chk({tag, ".u1pos"}, 32'(pos1), tbl[i].p1);
      chk({tag, ".u2pos"}, 32'(pos2), tbl[i].p2);
      chk({tag, ".u2reach"}, 32'(re2), tbl[i].r2);
    end

    // Dead hold: tick, deploy and damage all ignored; then IDLE at spawn.
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 4'b0001, 0, 1, 8'd10);
      chk_u0($sformatf("dead%0d", i), 3, 0, 0, 2, 0, 1, 0);
    end
    drive(1, 0, 4'b0000, 0, 0, 0);
    chk_u0("respawn_idle", 0, 0, 0, 2, 0, 0, 0);

    // Type 1 blocked for nine ticks: strobes on ticks 1, 5, 9.
    drive(1, 0, 4'b0010, 0, 0, 0);
    chk_u0("t1_deploy", 0, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 4'b0000, 0, 0, 0);
    chk_u0("t1_alive", 0, 0, 255, 1, 1, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      drive(1, 1, 4'b0000, 0, 0, 0);
      chk($sformatf("t1_tick%0d.dmg", i), 32'(dmg0), (i % 4 == 1) ? 32 : 0);
    end

    // Exact-health hit kills, then full hold back to IDLE.
    drive(1, 0, 4'b0000, 0, 1, 8'd255);
    chk_u0("kill255", 0, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 4'b0000, 0, 0, 0);
      chk($sformatf("hold%0d.dead", i), 32'(de0), 1);
    end
    drive(1, 0, 4'b0000, 0, 0, 0);
    chk_u0("idle2", 0, 0, 0, 1, 0, 0, 0);

    // Multi-bit deploy request is rejected.
    drive(1, 0, 4'b0110, 0, 0, 0);
    chk_u0("multi_dep", 0, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 4'b0000, 0, 0, 0);
    chk_u0("multi_dep2", 0, 0, 0, 1, 0, 0, 0);

    // Type 3 power is 128.
    drive(1, 0, 4'b1000, 0, 0, 0);
    chk_u0("t3_deploy", 0, 0, 0, 3, 0, 0, 0);
    drive(1, 0, 4'b0000, 0, 0, 0);
    chk_u0("t3_alive", 0, 0, 255, 3, 1, 0, 0);
    drive(1, 1, 4'b0000, 0, 0, 0);
    chk_u0("t3_attack", 0, 128, 255, 3, 1, 0, 0);

    // Reset in the middle of DEAD returns to reset values immediately.
    drive(1, 0, 4'b0000, 0, 1, 8'd255);
    chk_u0("t3_kill", 0, 0, 0, 3, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 4'b0000, 0, 0, 0);
    chk("middead.dead", 32'(de0), 1);
    drive(0, 0, 4'b0000, 0, 0, 0);
    chk_u0("rst_middead", 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 4'b0000, 0, 0, 0);
    chk_u0("post_rst", 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/combat_unit.md
# combat_unit

Parametrised lane unit: the next generation of the single enemy unit, usable for both enemy and player units. The unit deploys from a one-hot type select and walks along the lane on game ticks. It attacks on a cooldown while blocked, takes damage from the top-level arbiter, and holds a dead state before returning to idle. Top level instantiates one per lane slot and drives the move/damage scenario enables.

## Interface
- POS_W, 9: position width
- HP_W, 8: health width
- DMG_W, 8: damage/power width
- NUM_TYPES, 4: number of deployable unit types (≥1); TW = max(1, $clog2(NUM_TYPES))
- HP_MAX, 255: health loaded on deploy
- POWER_BASE, 16: power of type 0; type k power = POWER_BASE << k, saturated to all-ones if it overflows DMG_W
- START_POS, 0: spawn position
- END_POS, 319: lane end (opponent base)
- DIR, 0: 0 = position increments, 1 = position decrements
- ATTACK_PERIOD, 4: game ticks between attack strobes (≥1)
- DEAD_HOLD, 10: cycles spent in DEAD

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- game_tick  in  1  one-cycle movement/attack enable
- deploy_req  in  NUM_TYPES  one-hot type select
- move_scen  in  1  1 = lane ahead clear (move), 0 = blocked (attack)
- damage_scen  in  1  apply damage_in this cycle
- damage_in  in  DMG_W  incoming damage
- position  out  POS_W  current position
- damage_out  out  DMG_W  attack strobe value, 0 when not attacking
- health  out  HP_W  current health
- unit_type  out  TW  latched type index
- alive  out  1  high in ALIVE
- dead  out  1  high in DEAD
- reached_end  out  1  high while position == END_POS in ALIVE

## Operation
- States: IDLE, DEPLOY, ALIVE, DEAD. All outputs are registered.
- IDLE: position = START_POS, health = 0, damage_out = 0. When deploy_req has exactly one bit set, latch its index into unit_type and go to DEPLOY. Zero bits or multiple bits set: stay in IDLE.
- DEPLOY (1 cycle): health <= HP_MAX, power <= type power, position <= START_POS, cooldown <= 0, then go to ALIVE.
- ALIVE, damage: on damage_scen, if damage_in >= health then health <= 0 and go to DEAD. Otherwise health <= health − damage_in. No wrap.
- ALIVE, tick with move_scen=1: step position by 1 in direction DIR, clamped at END_POS. damage_out <= 0. cooldown <= 0.
- ALIVE, tick with move_scen=0: if cooldown == 0, damage_out <= power for that one cycle and cooldown <= ATTACK_PERIOD−1. Otherwise cooldown decrements.
- ALIVE, no tick: damage_out <= 0.
- Kill and tick in the same cycle: the kill wins. No move, damage_out <= 0.
- DEAD: damage_out = 0, position and health frozen. A counter runs for DEAD_HOLD cycles, then the unit goes to IDLE with position reset to START_POS.
- deploy_req is ignored outside IDLE.
- damage_scen is ignored outside ALIVE.

## Timing
- Reset (reset=0 at a clk edge) overrides everything, including mid-deploy and mid-DEAD. Reset values: state IDLE, position START_POS, health 0, damage_out 0, unit_type 0, alive 0, dead 0, reached_end 0, cooldown 0, dead counter 0.
- deploy_req seen at edge N: DEPLOY at N+1, ALIVE with health = HP_MAX at N+2.
- Position and damage_out update at the edge after the tick cycle. damage_out is a one-cycle pulse.
- A lethal hit at edge N: dead = 1 and alive = 0 from N+1, for exactly DEAD_HOLD cycles, then IDLE.
- A continuously blocked unit strobes at ticks 0, P, 2P, … where P = ATTACK_PERIOD.

## Test plan
- Reset with deploy_req=4'b0100 held → unit stays in IDLE with all outputs at reset values. Release reset → ALIVE 2 cycles later, unit_type=2, health=255, power 64.
- Type 3, three ticks with move_scen=1, DIR=0 → position=3, damage_out stays 0. Repeat with DIR=1 and START_POS=319 → position=316.
- Type 1, move_scen=0, 9 consecutive ticks → damage_out=32 after ticks 1, 5 and 9 only. Set move_scen=1 for one tick, then 0 → next blocked tick strobes immediately.
- health=255, damage 200 → 55. Damage 55 together with a tick → dead next cycle, damage_out 0, position unchanged. After 10 cycles → IDLE, position=0, and a new deploy is accepted.
- deploy_req=4'b0110, then 4'b0000 → remains in IDLE. deploy_req pulse while ALIVE → ignored.
- START_POS=317, END_POS=319, 5 move ticks → position clamps at 319, reached_end=1. Assert reset mid-DEAD → IDLE next cycle.
